gcd_arbiter: RTL and testbench
==============================

GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-004 req0, req1  input  1 each  request from requester 0 or 1, level, sampled only in IDLE.
REQ-005 a0, b0, a1, b1  input  WIDTH each  operands of requester 0 or 1, valid while the matching req is high.
REQ-006 gnt0, gnt1  output  1 each  grant; high for exactly the IDLE cycle in which that requester's operands are captured.
REQ-007 done0, done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-008 gcd_val  output  WIDTH  registered result, valid when done0 or done1 is high, held until the next completion.
REQ-009 busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, CALC and DONE.
REQ-011 In IDLE, with any req high, the block SHALL grant one requester, capture that requester's a and b into working registers x and y on that edge, and move to CALC.
REQ-012 Arbitration SHALL be round-robin: a 1-bit priority pointer names the preferred requester; after a grant to requester i the pointer SHALL point to the other requester.
REQ-013 With a single req high, that requester SHALL be granted regardless of the pointer.
REQ-014 In each CALC cycle, if x==0 the result SHALL be y; otherwise if y==0 the result SHALL be x; otherwise if x==y the result SHALL be x; in these three cases the block SHALL latch the result into gcd_val and move to DONE.
REQ-015 Otherwise, in CALC, the larger of x and y SHALL be replaced by (larger - smaller), with no wrap (unsigned, WIDTH bits), and the state SHALL remain CALC.
REQ-016 gcd(0,0) SHALL be 0.
REQ-017 In DONE, the block SHALL assert done for the granted requester for one cycle and return to IDLE; no grant SHALL occur in DONE.
REQ-018 Latency SHALL be as follows: grant in cycle 0, CALC from cycle 1, done in cycle (subtractions + 2). Worst case for WIDTH=4 is operands (15,1): done in cycle 16.
REQ-019 A req that is deasserted before IDLE SHALL be ignored; a req still high in IDLE after its done SHALL be treated as a new request.
REQ-020 Operand changes after the grant SHALL NOT affect the running computation.

Reset
REQ-021 While reset==0 at a clk edge, the block SHALL enter IDLE and clear gnt0, gnt1, done0, done1, busy, gcd_val, x, y, and the priority pointer (pointer = requester 0).
REQ-022 A reset asserted during CALC or DONE SHALL abort the computation and produce no done pulse.

Structure
REQ-023 A shared package gcd_pkg SHALL hold the WIDTH default and the FSM state encoding; the team's gcd blocks SHALL share it.
REQ-024 The subtract/compare datapath (x, y, zero/equal detection) SHALL be one sub-module gcd_engine with start, operands, done and result ports; arbitration and the FSM SHALL stay in gcd_arbiter.

Verification
REQ-025 req0 with (8,4) after reset -> gnt0 in cycle 0, done0 in cycle 3, gcd_val=4, busy high in cycles 1-3.
REQ-026 req0 (14,4) and req1 (10,9) raised together and held -> gnt0 first, done0 in cycle 6 with gcd_val=2; then gnt1 in the next IDLE cycle, done1 with gcd_val=1.
REQ-027 Zero operands: (0,6) -> done in cycle 2 with gcd_val=6; (0,0) -> done in cycle 2 with gcd_val=0.
REQ-028 (15,1) -> done in cycle 16 with gcd_val=1; busy high in cycles 1-16.
REQ-029 req1 held high continuously while req0 is re-raised after every done -> grants alternate 0,1,0,1 with no starvation.
REQ-030 reset=0 in the third CALC cycle of (15,1) -> next cycle all outputs 0 and no done; a following req1 (9,6) is granted and returns gcd_val=3.

Source files
------------

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared width default and FSM state encoding for gcd blocks
package gcd_pkg;

    localparam int GCD_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - subtractive gcd datapath (ports: clk, reset, start, a, b -> done, result)
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,   // synchronous, active-low
    input  logic             start,   // load a/b into x/y on this edge
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,    // x/y have reached a terminal pair
    output logic [WIDTH-1:0] result   // gcd of the loaded operands while done
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    // A terminal pair (zero or equal operand) never changes under the step
    // rule below, so the registers simply hold once done is reached.
    always_comb begin
        done   = (x == '0) || (y == '0) || (x == y);
        result = (x == '0) ? y : x;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (start) begin
            x <= a;
            y <= b;
        end else if (!done) begin
            // Larger minus smaller only, so the difference never wraps.
            if (x > y) begin
                x <= x - y;
            end else begin
                y <= y - x;
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - round-robin two-requester front end for gcd_engine (ports: req/a/b per requester -> gnt, done, gcd_val, busy)
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,    // synchronous, active-low
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] gcd_val,
    output logic             busy
);

    gcd_state_t       state;
    gcd_state_t       state_nxt;
    logic             ptr;        // preferred requester when both ask
    logic             owner;      // requester whose job is in flight
    logic             pick;
    logic             grant_en;
    logic             eng_done;
    logic [WIDTH-1:0] eng_result;

    // Contention goes to the pointer; a lone request wins outright.
    always_comb begin
        if (req0 && req1) begin
            pick = ptr;
        end else begin
            pick = req1;
        end
        // Gated by reset so no grant is shown on a cycle whose edge resets.
        grant_en = (state == ST_IDLE) && reset && (req0 || req1);
    end

    gcd_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk    (clk),
        .reset  (reset),
        .start  (grant_en),
        .a      (pick ? a1 : a0),
        .b      (pick ? b1 : b0),
        .done   (eng_done),
        .result (eng_result)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_en) state_nxt = ST_CALC;
            ST_CALC: if (eng_done) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt0  = grant_en && !pick;
        gnt1  = grant_en && pick;
        busy  = (state != ST_IDLE);
        done0 = (state == ST_DONE) && !owner;
        done1 = (state == ST_DONE) && owner;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr     <= 1'b0;
            owner   <= 1'b0;
            gcd_val <= '0;
        end else begin
            if (grant_en) begin
                owner <= pick;
                ptr   <= ~pick;
            end
            if ((state == ST_CALC) && eng_done) begin
                gcd_val <= eng_result;
            end
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb/tb_gcd_arbiter.sv - directed self-checking bench for gcd_arbiter
module tb_gcd_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] a0 = '0;
    logic [3:0] b0 = '0;
    logic [3:0] a1 = '0;
    logic [3:0] b1 = '0;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [3:0] gcd_val;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    gcd_arbiter #(
        .WIDTH (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done0   (done0),
        .done1   (done1),
        .gcd_val (gcd_val),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Entered in cycle 1 (first CALC cycle); counts cycles until the done pulse.
    task automatic wait_done(input string tag, input int who, input int exp_cyc, input logic [3:0] exp_val);
        int cyc     = 1;
        bit seen    = 1'b0;
        bit busy_ok = 1'b1;
        bit other   = 1'b0;
        bit granted = 1'b0;
        while (cyc <= 40 && !seen) begin
            if (!busy) busy_ok = 1'b0;
            if (gnt0 || gnt1) granted = 1'b1;
            if ((who == 0) ? done1 : done0) other = 1'b1;
            if ((who == 0) ? done0 : done1) begin
                seen = 1'b1;
            end else begin
                step();
                cyc++;
            end
        end
        check({tag, "_done_cycle"}, seen ? cyc : 0, exp_cyc);
        check({tag, "_gcd_val"}, 32'(gcd_val), 32'(exp_val));
        check({tag, "_busy_high"}, 32'(busy_ok), 1);
        check({tag, "_no_grant_while_busy"}, 32'(granted), 0);
        check({tag, "_other_done_quiet"}, 32'(other), 0);
    endtask

    // Single requester job, operands scrambled right after capture.
    task automatic run_one(input string tag, input int who, input logic [3:0] a, input logic [3:0] b,
                           input int exp_cyc, input logic [3:0] exp_val);
        if (who == 0) begin
            a0 = a; b0 = b; req0 = 1'b1;
        end else begin
            a1 = a; b1 = b; req1 = 1'b1;
        end
        #1;
        check({tag, "_gnt0"}, 32'(gnt0), (who == 0) ? 1 : 0);
        check({tag, "_gnt1"}, 32'(gnt1), (who == 1) ? 1 : 0);
        step();
        req0 = 1'b0; req1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        wait_done(tag, who, exp_cyc, exp_val);
        step();
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_done_one_cycle"}, 32'(done0 | done1), 0);
    endtask

    initial begin
        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'({gnt0, gnt1}), 0);
        check("rst_done", 32'({done0, done1}), 0);
        check("rst_gcd_val", 32'(gcd_val), 0);

        run_one("r8_4", 0, 4'd8, 4'd4, 3, 4'd4);
        run_one("r0_6", 1, 4'd0, 4'd6, 2, 4'd6);
        run_one("r0_0", 0, 4'd0, 4'd0, 2, 4'd0);
        run_one("r6_0", 1, 4'd6, 4'd0, 2, 4'd6);
        run_one("r15_1", 0, 4'd15, 4'd1, 16, 4'd1);

        // Abort in the third CALC cycle of (15,1); gcd_val currently 1.
        a0 = 4'd15; b0 = 4'd1; req0 = 1'b1;
        #1;
        check("abort_gnt0", 32'(gnt0), 1);
        step();
        req0 = 1'b0;
        step();
        step();
        check("abort_busy_c3", 32'(busy), 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'({done0, done1}), 0);
        check("abort_gnt", 32'({gnt0, gnt1}), 0);
        check("abort_gcd_val", 32'(gcd_val), 0);
        begin
            bit stray = 1'b0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (done0 || done1 || busy) stray = 1'b1;
            end
            check("abort_no_done", 32'(stray), 0);
        end
        run_one("r9_6", 1, 4'd9, 4'd6, 4, 4'd3);

        // Simultaneous requests held: 0 wins first after reset, then 1.
        do_reset();
        a0 = 4'd14; b0 = 4'd4; a1 = 4'd10; b1 = 4'd9;
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("both_gnt0", 32'(gnt0), 1);
        check("both_gnt1", 32'(gnt1), 0);
        step();
        wait_done("both_0", 0, 6, 4'd2);
        step();
        check("both_second_gnt1", 32'(gnt1), 1);
        check("both_second_gnt0", 32'(gnt0), 0);
        step();
        req0 = 1'b0; req1 = 1'b0;
        wait_done("both_1", 1, 11, 4'd1);
        step();

        // req1 held throughout, req0 re-raised in every IDLE: grants alternate.
        do_reset();
        a0 = 4'd2; b0 = 4'd2; a1 = 4'd5; b1 = 4'd5;
        req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0 = 1'b1;
            #1;
            check($sformatf("rr%0d_gnt0", i), 32'(gnt0), (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_gnt1", i), 32'(gnt1), (i % 2 == 1) ? 1 : 0);
            step();
            req0 = 1'b0;
            wait_done($sformatf("rr%0d", i), i % 2, 2, (i % 2 == 0) ? 4'd2 : 4'd5);
            step();
        end
        req1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
